lbu_ptr_op_issuer: RTL

- Initiator side of the line-buffer pointer-op interface.
- Accepts a traversal command and emits a sequence of pointer opcodes (None/Rst/Incr/Decr) with stride over a valid/ready link to the pointer register block.
- Keeps a shadow copy of the pointer, modulo DEPTH, so upstream control sees the pointer value and wrap-around events without reading the register block.

---
 rtl/lbu_ptr_op_issuer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lbu_ptr_op_issuer.sv
// lbu_ptr_op_issuer: line-buffer pointer-op initiator with a modulo-DEPTH shadow pointer
//   Ports:
//     clk, rst        clock, async active-high reset
//     cmd_*           traversal command (valid/ready, rst_first, dir, stride, len)
//     op_*            pointer-op link to the register block (valid/ready, code, stride)
//     ptr_shadow      shadow copy of the pointer, modulo DEPTH
//     wrap_pulse      one-cycle pulse when a step wraps around
//     done_pulse      one-cycle pulse when a command completes
//     busy            FSM not idle
//     stall_cnt       saturating backpressure cycle count (LBU_PTR_OP_ISSUER_STALL_CNT_EN only)
//   Optional macro: LBU_PTR_OP_ISSUER_STALL_CNT_EN
module lbu_ptr_op_issuer #(
  parameter int P_MODE = 3,
  parameter int P_STRIDE = 3,
  parameter int PTR_W = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 8,
  parameter logic [P_MODE-1:0] P_PTROPNONE = 3'd0,
  parameter logic [P_MODE-1:0] P_PTROPRST = 3'd1,
  parameter logic [P_MODE-1:0] P_PTROPINCR = 3'd2,
  parameter logic [P_MODE-1:0] P_PTROPDECR = 3'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rst_first,
  input  logic                cmd_dir,
  input  logic [P_STRIDE-1:0] cmd_stride,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [P_MODE-1:0]   op_code,
  output logic [P_STRIDE-1:0] op_stride,
  output logic [PTR_W-1:0]    ptr_shadow,
  output logic                wrap_pulse,
  output logic                done_pulse,
  output logic                busy
`ifdef LBU_PTR_OP_ISSUER_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RST, STEP, DONE} state_t;
  localparam logic [PTR_W:0] DEPTH_X = (PTR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic dir_q, dir_d, wrap_q, wrap_d;
  logic [P_STRIDE-1:0] stride_q, stride_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0] ptr_x, str_x, inc_s, nxt_s;
  logic inc_w, dec_w;
  // One extra bit keeps the incremented sum and the decrement borrow exact before folding back into [0, DEPTH).
  assign ptr_x = {1'b0, ptr_q};
  assign str_x = (PTR_W+1)'(stride_q);
  assign inc_s = ptr_x + str_x;
  assign inc_w = inc_s >= DEPTH_X;
  assign dec_w = ptr_x < str_x;
  assign nxt_s = dir_q ? (dec_w ? ptr_x + DEPTH_X - str_x : ptr_x - str_x)
                       : (inc_w ? inc_s - DEPTH_X : inc_s);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      stride_q <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      wrap_q   <= wrap_d;
    end
  // op_valid is constant-high in RST and STEP, so op_ready alone marks a handshake there.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    stride_d = stride_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    wrap_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        dir_d    = cmd_dir;
        stride_d = cmd_stride;
        len_d    = cmd_len;
        state_d  = cmd_rst_first ? RST : (|cmd_len ? STEP : DONE);
      end
      RST: if (op_ready) begin
        ptr_d   = '0;
        state_d = |len_q ? STEP : DONE;
      end
      STEP: if (op_ready) begin
        ptr_d   = nxt_s[PTR_W-1:0];
        wrap_d  = dir_q ? dec_w : inc_w;
        len_d   = len_q - LEN_W'(1);
        state_d = len_q == LEN_W'(1) ? DONE : STEP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_valid   = state_q == RST || state_q == STEP;
    op_code    = state_q == RST ? P_PTROPRST
               : state_q == STEP ? (stride_q == '0 ? P_PTROPNONE : (dir_q ? P_PTROPDECR : P_PTROPINCR))
               : P_PTROPNONE;
    op_stride  = state_q == STEP ? stride_q : '0;
    done_pulse = state_q == DONE;
    busy       = state_q != IDLE;
    cmd_ready  = state_q == IDLE && !rst;
    ptr_shadow = ptr_q;
    wrap_pulse = wrap_q;
  end
`ifdef LBU_PTR_OP_ISSUER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == IDLE && cmd_valid) ? '0
            : (op_valid && !op_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cnt = stall_q;
`endif
endmodule
